// File: rtl/div_pipe_16by8_if.sv
`default_nettype none
// ============================================================================
// Module      : div_pipe_16by8_if
// Description : Streaming operand/result bundle for the pipelined 16/8 divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface div_pipe_16by8_if;
    logic        div_en_in;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic        div_en_out;
    logic [15:0] div_quo;
    logic [7:0]  div_rem;
    logic        div_zero;

    modport master (
        output div_en_in, div_a, div_b,
        input  div_en_out, div_quo, div_rem, div_zero
    );

    modport slave (
        input  div_en_in, div_a, div_b,
        output div_en_out, div_quo, div_rem, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/div_pipe_16by8.sv
`default_nettype none
// ============================================================================
// Module      : div_pipe_16by8
// Description : Fully pipelined unsigned restoring divider, 16-bit / 8-bit,
//               one operation per clock, latency 16/BITS_PER_STAGE + 2 edges.
// Revision    : 1.0 - initial release
// ============================================================================
module div_pipe_16by8 #(
    parameter int BITS_PER_STAGE = 2
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    div_pipe_16by8_if.slave   bus
);

    localparam int NSTG = 16 / BITS_PER_STAGE;

    // Dividend and quotient share one shift register per stage: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    logic        r_vld  [0:NSTG];
    logic [15:0] r_dq   [0:NSTG];
    logic        r_zero [0:NSTG];
    logic [7:0]  r_dvs  [0:NSTG-1];
    logic [7:0]  r_rem  [1:NSTG];

    logic [7:0]  w_rem_in  [1:NSTG];
    logic [7:0]  w_rem_nxt [1:NSTG];
    logic [15:0] w_dq_nxt  [1:NSTG];

    logic        r_en_out;
    logic [15:0] r_quo_out;
    logic [7:0]  r_rem_out;
    logic        r_zero_out;

    always_comb begin
        w_rem_in[1] = '0;
        for (int s = 2; s <= NSTG; s++) begin
            w_rem_in[s] = r_rem[s-1];
        end
    end

    // A kept remainder is always below the divisor, so 8 bits hold it exactly;
    // only the shifted trial value needs the ninth bit.
    always_comb begin
        logic [8:0] w_trial;
        logic       w_ge;
        w_trial = '0;
        w_ge    = 1'b0;
        for (int s = 1; s <= NSTG; s++) begin
            w_rem_nxt[s] = w_rem_in[s];
            w_dq_nxt[s]  = r_dq[s-1];
            for (int i = 0; i < BITS_PER_STAGE; i++) begin
                w_trial      = {w_rem_nxt[s], w_dq_nxt[s][15]};
                w_ge         = (w_trial >= {1'b0, r_dvs[s-1]});
                w_rem_nxt[s] = w_ge ? 8'(w_trial - {1'b0, r_dvs[s-1]}) : w_trial[7:0];
                w_dq_nxt[s]  = {w_dq_nxt[s][14:0], w_ge};
            end
        end
    end

    // A zero divisor needs no special case: every trial succeeds (quotient all
    // ones) and the remainder register ends up holding the low dividend bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s <= NSTG; s++) begin
                r_vld[s]  <= 1'b0;
                r_dq[s]   <= '0;
                r_zero[s] <= 1'b0;
            end
            for (int s = 0; s < NSTG; s++) begin
                r_dvs[s] <= '0;
            end
            for (int s = 1; s <= NSTG; s++) begin
                r_rem[s] <= '0;
            end
            r_en_out   <= 1'b0;
            r_quo_out  <= '0;
            r_rem_out  <= '0;
            r_zero_out <= 1'b0;
        end else begin
            r_vld[0] <= bus.div_en_in;
            if (bus.div_en_in) begin
                r_dq[0]   <= bus.div_a;
                r_dvs[0]  <= bus.div_b;
                r_zero[0] <= (bus.div_b == 8'd0);
            end
            for (int s = 1; s <= NSTG; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_dq[s]   <= w_dq_nxt[s];
                r_rem[s]  <= w_rem_nxt[s];
                r_zero[s] <= r_zero[s-1];
            end
            for (int s = 1; s < NSTG; s++) begin
                r_dvs[s] <= r_dvs[s-1];
            end
            r_en_out   <= r_vld[NSTG];
            r_quo_out  <= r_vld[NSTG] ? r_dq[NSTG]   : 16'd0;
            r_rem_out  <= r_vld[NSTG] ? r_rem[NSTG]  : 8'd0;
            r_zero_out <= r_vld[NSTG] ? r_zero[NSTG] : 1'b0;
        end
    end

    assign bus.div_en_out = r_en_out;
    assign bus.div_quo    = r_quo_out;
    assign bus.div_rem    = r_rem_out;
    assign bus.div_zero   = r_zero_out;

endmodule
`default_nettype wire

// File: tb/tb_div_pipe_16by8.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_pipe_16by8
// Description : Directed self-checking bench for div_pipe_16by8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_pipe_16by8;

    localparam int L = 10;

    typedef struct {
        int          cyc;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t expq[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_pipe_16by8_if bus();

    div_pipe_16by8 #(.BITS_PER_STAGE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of input; an enabled op is expected L edges later,
    // counting its own sampling edge.
    task automatic drive(input logic en, input logic [15:0] a, input logic [7:0] b,
                         input logic [15:0] q, input logic [7:0] r, input logic z);
        @(negedge clk);
        bus.div_en_in = en;
        bus.div_a     = a;
        bus.div_b     = b;
        if (en) expq.push_back('{cyc + L, q, r, z});
    endtask

    task automatic idle(input int n);
        logic [31:0] rnd;
        for (int i = 0; i < n; i++) begin
            rnd = $urandom;
            drive(1'b0, rnd[15:0], rnd[23:16], 16'd0, 8'd0, 1'b0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.div_en_out === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", {31'd0, bus.div_en_out}, 32'd0);
            end else begin
                e = expq.pop_front();
                check("latency", cyc, e.cyc);
                check("quo", {16'd0, bus.div_quo}, {16'd0, e.q});
                check("rem", {24'd0, bus.div_rem}, {24'd0, e.r});
                check("zero", {31'd0, bus.div_zero}, {31'd0, e.z});
            end
        end else begin
            check("idle_out", {bus.div_en_out, bus.div_quo, bus.div_rem, bus.div_zero}, 32'd0);
        end
    end

    initial begin
        logic [5:0]  pat;
        logic [31:0] rnd;
        logic [15:0] ra;
        logic [7:0]  rb;

        rst_n         = 1'b0;
        bus.div_en_in = 1'b0;
        bus.div_a     = '0;
        bus.div_b     = '0;
        repeat (2) @(negedge clk);
        check("reset_out", {bus.div_en_out, bus.div_quo, bus.div_rem, bus.div_zero}, 32'd0);
        rst_n = 1'b1;

        // single op
        drive(1'b1, 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        idle(L + 2);

        // back-to-back
        drive(1'b1, 16'd100, 8'd3,  16'd33, 8'd1, 1'b0);
        drive(1'b1, 16'd200, 8'd9,  16'd22, 8'd2, 1'b0);
        drive(1'b1, 16'd50,  8'd50, 16'd1,  8'd0, 1'b0);
        idle(L + 2);

        // boundaries
        drive(1'b1, 16'd65535, 8'd255, 16'd257,   8'd0, 1'b0);
        drive(1'b1, 16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0);
        drive(1'b1, 16'd5,     8'd200, 16'd0,     8'd5, 1'b0);
        drive(1'b1, 16'd0,     8'd13,  16'd0,     8'd0, 1'b0);
        idle(L + 2);

        // divide by zero followed by a normal op
        drive(1'b1, 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);
        drive(1'b1, 16'd77,   8'd7, 16'd11,   8'd0,  1'b0);
        idle(L + 2);

        // gapped stream 1,0,1,1,0,1
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            ra  = rnd[15:0];
            rb  = 8'($urandom_range(1, 255));
            drive(pat[5-i], ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0);
        end
        idle(L + 2);

        // reset mid-flight: a prior result sits on the outputs when reset hits
        drive(1'b1, 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);
        idle(6);
        drive(1'b1, 16'd300, 8'd4,  16'd75,  8'd0, 1'b0);
        drive(1'b1, 16'd301, 8'd4,  16'd75,  8'd1, 1'b0);
        drive(1'b1, 16'd302, 8'd4,  16'd75,  8'd2, 1'b0);
        drive(1'b1, 16'd303, 8'd4,  16'd75,  8'd3, 1'b0);
        #2;
        rst_n         = 1'b0;
        bus.div_en_in = 1'b0;
        expq.delete();
        #1;
        check("async_reset_out", {bus.div_en_out, bus.div_quo, bus.div_rem, bus.div_zero}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1'b1, 16'd4321, 8'd10, 16'd432, 8'd1, 1'b0);
        idle(L + 4);

        check("pending_results", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
